// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX operand forwarding selects, load-use stall insertion
// and taken-branch flushes, with saturating stall/flush event counters.
module hazard_ctrl #(
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic [4:0]       idex_rs,
    input  logic [4:0]       idex_rt,
    input  logic             idex_mem_read,
    input  logic             branch_taken,
    input  logic             exmem_reg_write,
    input  logic [4:0]       exmem_addr_dest,
    input  logic             memwb_reg_write,
    input  logic [4:0]       memwb_addr_dest,
    output logic             pc_write,
    output logic             cfe_write,
    output logic             cfe_flush,
    output logic             dex_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             busy
);

    typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_e;

    localparam logic [3:0] REM_INIT = 4'(LOAD_STALL - 1);

    state_e           state_q, state_d;
    logic [3:0]       rem_q, rem_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             stall_inc, flush_inc;
    logic             load_use;
    logic             ex_fwd_ok, wb_fwd_ok;

    // EX/MEM result is newer than MEM/WB, so it wins when both match.
    assign ex_fwd_ok = exmem_reg_write && (exmem_addr_dest != 5'd0);
    assign wb_fwd_ok = memwb_reg_write && (memwb_addr_dest != 5'd0);

    always_comb begin
        fwd_a = 2'b00;
        if (ex_fwd_ok && exmem_addr_dest == idex_rs)      fwd_a = 2'b10;
        else if (wb_fwd_ok && memwb_addr_dest == idex_rs) fwd_a = 2'b01;
        fwd_b = 2'b00;
        if (ex_fwd_ok && exmem_addr_dest == idex_rt)      fwd_b = 2'b10;
        else if (wb_fwd_ok && memwb_addr_dest == idex_rt) fwd_b = 2'b01;
    end

    assign load_use = idex_mem_read && (idex_rt != 5'd0) &&
                      ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        pc_write  = 1'b1;
        cfe_write = 1'b1;
        cfe_flush = 1'b0;
        dex_flush = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        case (state_q)
            RUN: begin
                if (branch_taken) begin
                    cfe_flush = 1'b1;
                    dex_flush = 1'b1;
                    flush_inc = 1'b1;
                end else if (load_use) begin
                    pc_write  = 1'b0;
                    cfe_write = 1'b0;
                    dex_flush = 1'b1;
                    stall_inc = 1'b1;
                    if (LOAD_STALL > 1) begin
                        state_d = STALL;
                        rem_d   = REM_INIT;
                    end
                end
            end
            STALL: begin
                // EX holds a bubble here, so branch/load_use are not looked at.
                pc_write  = 1'b0;
                cfe_write = 1'b0;
                dex_flush = 1'b1;
                stall_inc = 1'b1;
                rem_d     = rem_q - 4'd1;
                if (rem_q == 4'd1) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (stall_inc && stall_q != '1) stall_d = stall_q + CNT_W'(1);
        if (flush_inc && flush_q != '1) flush_d = flush_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            rem_q   <= 4'd0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_count = stall_q;
    assign flush_count = flush_q;
    assign busy        = (state_q == STALL);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (LOAD_STALL 1/3/2, the last with 4-bit counters)
// share stimulus and are checked against a bubble-count reference model.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] ifid_rs, ifid_rt, idex_rs, idex_rt, exmem_addr_dest, memwb_addr_dest;
    logic       idex_mem_read, branch_taken, exmem_reg_write, memwb_reg_write;

    logic        pcw [3];
    logic        cfw [3];
    logic        cff [3];
    logic        dxf [3];
    logic        bsy [3];
    logic [1:0]  fa  [3];
    logic [1:0]  fb  [3];
    logic [15:0] sc0, sc1, fc0, fc1;
    logic [3:0]  sc2, fc2;
    logic [15:0] scv [3];
    logic [15:0] fcv [3];

    assign scv[0] = sc0;
    assign scv[1] = sc1;
    assign scv[2] = {12'd0, sc2};
    assign fcv[0] = fc0;
    assign fcv[1] = fc1;
    assign fcv[2] = {12'd0, fc2};

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pending forced bubbles and event totals per instance.
    int ls_p [3] = '{1, 3, 2};
    int mx_p [3] = '{65535, 65535, 15};
    int pend [3];
    int sm   [3];
    int fm   [3];

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_STALL(1), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_mem_read(idex_mem_read),
        .branch_taken(branch_taken), .exmem_reg_write(exmem_reg_write),
        .exmem_addr_dest(exmem_addr_dest), .memwb_reg_write(memwb_reg_write),
        .memwb_addr_dest(memwb_addr_dest), .pc_write(pcw[0]), .cfe_write(cfw[0]),
        .cfe_flush(cff[0]), .dex_flush(dxf[0]), .fwd_a(fa[0]), .fwd_b(fb[0]),
        .stall_count(sc0), .flush_count(fc0), .busy(bsy[0]));

    hazard_ctrl #(.LOAD_STALL(3), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_mem_read(idex_mem_read),
        .branch_taken(branch_taken), .exmem_reg_write(exmem_reg_write),
        .exmem_addr_dest(exmem_addr_dest), .memwb_reg_write(memwb_reg_write),
        .memwb_addr_dest(memwb_addr_dest), .pc_write(pcw[1]), .cfe_write(cfw[1]),
        .cfe_flush(cff[1]), .dex_flush(dxf[1]), .fwd_a(fa[1]), .fwd_b(fb[1]),
        .stall_count(sc1), .flush_count(fc1), .busy(bsy[1]));

    hazard_ctrl #(.LOAD_STALL(2), .CNT_W(4)) u2 (
        .clk(clk), .rst(rst), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_mem_read(idex_mem_read),
        .branch_taken(branch_taken), .exmem_reg_write(exmem_reg_write),
        .exmem_addr_dest(exmem_addr_dest), .memwb_reg_write(memwb_reg_write),
        .memwb_addr_dest(memwb_addr_dest), .pc_write(pcw[2]), .cfe_write(cfw[2]),
        .cfe_flush(cff[2]), .dex_flush(dxf[2]), .fwd_a(fa[2]), .fwd_b(fb[2]),
        .stall_count(sc2), .flush_count(fc2), .busy(bsy[2]));

    task automatic set_idle();
        ifid_rs = 0; ifid_rt = 0; idex_rs = 0; idex_rt = 0;
        exmem_addr_dest = 0; memwb_addr_dest = 0;
        idex_mem_read = 0; branch_taken = 0; exmem_reg_write = 0; memwb_reg_write = 0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin pend[k] = 0; sm[k] = 0; fm[k] = 0; end
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    function automatic logic m_lu();
        return idex_mem_read && idex_rt != 0 && (idex_rt == ifid_rs || idex_rt == ifid_rt);
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] src);
        if (exmem_reg_write && exmem_addr_dest != 0 && exmem_addr_dest == src) return 2'b10;
        if (memwb_reg_write && memwb_addr_dest != 0 && memwb_addr_dest == src) return 2'b01;
        return 2'b00;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_tick();
        for (int k = 0; k < 3; k++) begin
            if (pend[k] > 0) begin
                pend[k]--;
                if (sm[k] < mx_p[k]) sm[k]++;
            end else if (branch_taken) begin
                if (fm[k] < mx_p[k]) fm[k]++;
            end else if (m_lu()) begin
                pend[k] = ls_p[k] - 1;
                if (sm[k] < mx_p[k]) sm[k]++;
            end
        end
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b0;
        #2;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (pcw[k] !== 1'b1 || cfw[k] !== 1'b1 || cff[k] !== 1'b0 || dxf[k] !== 1'b0 ||
                bsy[k] !== 1'b0 || scv[k] !== 16'd0 || fcv[k] !== 16'd0) begin
                n_fail++;
                $display("FAIL reset[%0d]: pcw=%b cfw=%b cff=%b dxf=%b busy=%b sc=%0d fc=%0d, want 1 1 0 0 0 0 0",
                         k, pcw[k], cfw[k], cff[k], dxf[k], bsy[k], scv[k], fcv[k]);
            end
        end
        // While held in reset, a branch still gets the RUN flush response.
        branch_taken = 1'b1;
        #1;
        n_tests++;
        if (cff[0] !== 1'b1 || dxf[0] !== 1'b1 || pcw[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_comb_branch: cff=%b dxf=%b pcw=%b, want 1 1 1", cff[0], dxf[0], pcw[0]);
        end
        do_reset();
    endtask

    task automatic test_fwd_priority();
        set_idle();
        exmem_reg_write = 1; exmem_addr_dest = 5;
        memwb_reg_write = 1; memwb_addr_dest = 5;
        idex_rs = 5; idex_rt = 5;
        #1;
        n_tests++;
        if (fa[0] !== 2'b10 || fb[0] !== 2'b10) begin
            n_fail++; $display("FAIL fwd_both: fwd_a=%b fwd_b=%b, want 10 10", fa[0], fb[0]);
        end
        exmem_reg_write = 0;
        #1;
        n_tests++;
        if (fa[0] !== 2'b01 || fb[0] !== 2'b01) begin
            n_fail++; $display("FAIL fwd_memwb: fwd_a=%b fwd_b=%b, want 01 01", fa[0], fb[0]);
        end
        exmem_reg_write = 1; exmem_addr_dest = 0; memwb_addr_dest = 0; idex_rs = 0; idex_rt = 0;
        #1;
        n_tests++;
        if (fa[0] !== 2'b00 || fb[0] !== 2'b00) begin
            n_fail++; $display("FAIL fwd_zero: fwd_a=%b fwd_b=%b, want 00 00", fa[0], fb[0]);
        end
        exmem_addr_dest = 7; memwb_addr_dest = 9; idex_rs = 9; idex_rt = 7;
        #1;
        n_tests++;
        if (fa[0] !== 2'b01 || fb[0] !== 2'b10) begin
            n_fail++; $display("FAIL fwd_split: fwd_a=%b fwd_b=%b, want 01 10", fa[0], fb[0]);
        end
        set_idle();
    endtask

    task automatic test_load_use();
        logic e_pcw1 [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic e_bsy1 [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        @(posedge clk); #1;
        idex_mem_read = 1; idex_rt = 8; ifid_rs = 8;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) begin
                n_tests++;
                if (pcw[0] !== 1'b0 || cfw[0] !== 1'b0 || dxf[0] !== 1'b1 || cff[0] !== 1'b0 || bsy[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lu1_cycle: pcw=%b cfw=%b dxf=%b cff=%b busy=%b, want 0 0 1 0 0",
                             pcw[0], cfw[0], dxf[0], cff[0], bsy[0]);
                end
            end
            if (c == 1) begin
                n_tests++;
                if (sc0 !== 16'd1 || bsy[0] !== 1'b0 || pcw[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL lu1_after: sc=%0d busy=%b pcw=%b, want 1 0 1", sc0, bsy[0], pcw[0]);
                end
            end
            n_tests++;
            if (pcw[1] !== e_pcw1[c] || bsy[1] !== e_bsy1[c] || dxf[1] !== !e_pcw1[c]) begin
                n_fail++;
                $display("FAIL lu3_cycle%0d: pcw=%b busy=%b dxf=%b, want %b %b %b",
                         c + 1, pcw[1], bsy[1], dxf[1], e_pcw1[c], e_bsy1[c], !e_pcw1[c]);
            end
            @(posedge clk); #1;
            set_idle();
        end
        n_tests++;
        if (sc1 !== 16'd3) begin
            n_fail++; $display("FAIL lu3_count: stall_count=%0d, want 3", sc1);
        end
    endtask

    task automatic test_branch_coincidence();
        do_reset();
        @(posedge clk); #1;
        idex_mem_read = 1; idex_rt = 8; ifid_rs = 8; branch_taken = 1;
        @(negedge clk);
        n_tests++;
        if (cff[1] !== 1'b1 || dxf[1] !== 1'b1 || pcw[1] !== 1'b1 || cfw[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL br_lu_cycle: cff=%b dxf=%b pcw=%b cfw=%b, want 1 1 1 1", cff[1], dxf[1], pcw[1], cfw[1]);
        end
        @(posedge clk); #1;
        set_idle();
        @(negedge clk);
        n_tests++;
        if (fc1 !== 16'd1 || sc1 !== 16'd0 || bsy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL br_lu_counts: flush=%0d stall=%0d busy=%b, want 1 0 0", fc1, sc1, bsy[1]);
        end
    endtask

    task automatic test_random();
        logic bub, fl;
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 400; i++) begin
            ifid_rs = 5'($urandom_range(0, 3));  ifid_rt = 5'($urandom_range(0, 3));
            idex_rs = 5'($urandom_range(0, 3));  idex_rt = 5'($urandom_range(0, 3));
            exmem_addr_dest = 5'($urandom_range(0, 3)); memwb_addr_dest = 5'($urandom_range(0, 3));
            exmem_reg_write = 1'($urandom); memwb_reg_write = 1'($urandom);
            idex_mem_read = ($urandom_range(0, 2) != 0);
            branch_taken  = ($urandom_range(0, 4) == 0);
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                bub = (pend[k] > 0) || (!branch_taken && m_lu());
                fl  = (pend[k] == 0) && branch_taken;
                n_tests++;
                if (pcw[k] !== !bub || cfw[k] !== !bub || cff[k] !== fl || dxf[k] !== (bub | fl) ||
                    bsy[k] !== (pend[k] > 0)) begin
                    n_fail++;
                    $display("FAIL rand_ctl[%0d] i=%0d: pcw=%b cfw=%b cff=%b dxf=%b busy=%b, want %b %b %b %b %b",
                             k, i, pcw[k], cfw[k], cff[k], dxf[k], bsy[k], !bub, !bub, fl, bub | fl, pend[k] > 0);
                end
                n_tests++;
                if (scv[k] !== 16'(sm[k]) || fcv[k] !== 16'(fm[k])) begin
                    n_fail++;
                    $display("FAIL rand_cnt[%0d] i=%0d: stall=%0d flush=%0d, want %0d %0d",
                             k, i, scv[k], fcv[k], sm[k], fm[k]);
                end
                n_tests++;
                if (fa[k] !== m_fwd(idex_rs) || fb[k] !== m_fwd(idex_rt)) begin
                    n_fail++;
                    $display("FAIL rand_fwd[%0d] i=%0d: fwd_a=%b fwd_b=%b, want %b %b",
                             k, i, fa[k], fb[k], m_fwd(idex_rs), m_fwd(idex_rt));
                end
            end
            model_tick();
            @(posedge clk); #1;
        end
        set_idle();
    endtask

    task automatic test_saturation_reset();
        do_reset();
        @(posedge clk); #1;
        idex_mem_read = 1; idex_rt = 8; ifid_rs = 8;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            model_tick();
            @(posedge clk); #1;
        end
        set_idle();
        @(negedge clk);
        n_tests++;
        if (sc2 !== 4'd15 || scv[0] !== 16'(sm[0]) || scv[1] !== 16'(sm[1])) begin
            n_fail++;
            $display("FAIL sat_count: sc2=%0d sc0=%0d sc1=%0d, want 15 %0d %0d", sc2, scv[0], scv[1], sm[0], sm[1]);
        end
        repeat (3) @(posedge clk);
        #1;
        idex_mem_read = 1; idex_rt = 8; ifid_rs = 8;
        @(posedge clk); #1;
        set_idle();
        @(negedge clk);
        n_tests++;
        if (bsy[1] !== 1'b1 || pcw[1] !== 1'b0) begin
            n_fail++; $display("FAIL midstall_pre: busy=%b pcw=%b, want 1 0", bsy[1], pcw[1]);
        end
        #2 rst = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (pcw[k] !== 1'b1 || bsy[k] !== 1'b0 || scv[k] !== 16'd0 || fcv[k] !== 16'd0) begin
                n_fail++;
                $display("FAIL midstall_rst[%0d]: pcw=%b busy=%b sc=%0d fc=%0d, want 1 0 0 0",
                         k, pcw[k], bsy[k], scv[k], fcv[k]);
            end
        end
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bsy[1] !== 1'b0 || pcw[1] !== 1'b1 || sc1 !== 16'd0) begin
            n_fail++; $display("FAIL midstall_release: busy=%b pcw=%b sc=%0d, want 0 1 0", bsy[1], pcw[1], sc1);
        end
    endtask

    initial begin
        set_idle();
        model_reset();
        test_reset();
        test_fwd_priority();
        test_load_use();
        test_branch_coincidence();
        test_random();
        test_saturation_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter LOAD_STALL, default 1: number of bubble cycles inserted per load-use hazard (legal range 1..15).
REQ-002 Parameter CNT_W, default 16: width of the event counters.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 ifid_rs, ifid_rt  in  5 each  source register fields of the instruction held in the fetch/decode buffer.
REQ-006 idex_rs, idex_rt  in  5 each  source register fields of the instruction held in the decode/execute buffer.
REQ-007 idex_mem_read  in  1  instruction in EX is a load.
REQ-008 branch_taken  in  1  branch resolved as taken in EX this cycle.
REQ-009 exmem_reg_write, exmem_addr_dest  in  1, 5  write-back control and destination from the execute/memory buffer.
REQ-010 memwb_reg_write, memwb_addr_dest  in  1, 5  write-back control and destination from the memory/write-back buffer.
REQ-011 pc_write  out  1  PC update enable.
REQ-012 cfe_write  out  1  fetch/decode buffer load enable.
REQ-013 cfe_flush  out  1  clears the fetch/decode buffer to a NOP.
REQ-014 dex_flush  out  1  clears all control fields of the decode/execute buffer, producing a bubble.
REQ-015 fwd_a, fwd_b  out  2 each  ALU operand source select: 00 = register file, 10 = EX/MEM result, 01 = MEM/WB result.
REQ-016 stall_count, flush_count  out  CNT_W each  event counters.
REQ-017 busy  out  1  high while the FSM is in state STALL.

Function
REQ-018 Forwarding is purely combinational; fwd_a SHALL be 10 when exmem_reg_write=1, exmem_addr_dest!=0, and exmem_addr_dest==idex_rs.
REQ-019 Otherwise fwd_a SHALL be 01 when memwb_reg_write=1, memwb_addr_dest!=0, and memwb_addr_dest==idex_rs.
REQ-020 In all remaining cases fwd_a SHALL be 00; fwd_b SHALL follow the same rules using idex_rt.
REQ-021 load_use is defined as idex_mem_read & (idex_rt!=0) & (idex_rt==ifid_rs | idex_rt==ifid_rt).
REQ-022 The FSM SHALL have two states, RUN and STALL, plus a 4-bit down-counter rem_cnt.
REQ-023 RUN, branch_taken=1 (priority over load_use): cfe_flush=1, dex_flush=1, pc_write=1, cfe_write=1; flush_count increments; next state RUN.
REQ-024 RUN, load_use=1, branch_taken=0: pc_write=0, cfe_write=0, dex_flush=1, cfe_flush=0; stall_count increments.
REQ-025 In the load_use case of REQ-024, the next state SHALL be STALL with rem_cnt=LOAD_STALL-1 when LOAD_STALL>1, and RUN otherwise.
REQ-026 RUN, neither condition: pc_write=1, cfe_write=1, both flushes 0, no counter change.
REQ-027 STALL: pc_write=0, cfe_write=0, dex_flush=1, cfe_flush=0; stall_count increments; rem_cnt decrements.
REQ-028 STALL SHALL return to RUN on the cycle in which rem_cnt==1.
REQ-029 branch_taken and load_use SHALL be ignored in STALL, because EX holds a bubble.
REQ-030 Stall/flush outputs are Mealy outputs, valid in the same cycle as the detecting inputs; there is no added latency.
REQ-031 Both counters SHALL saturate at all-ones and never wrap.
REQ-032 An instruction stalled in decode SHALL be re-evaluated each cycle; a hazard that persists after STALL exits re-enters per REQ-024.

Reset
REQ-033 While rst=0: state=RUN, rem_cnt=0, stall_count=0, flush_count=0.
REQ-034 While rst=0, the combinational outputs SHALL follow the RUN rules of REQ-023 to REQ-026.
REQ-035 Reset asserted mid-STALL SHALL abort the stall immediately; on release, the block resumes in RUN with counters at 0.

Verification
REQ-036 Forwarding priority: exmem (reg_write=1, dest=5), memwb (reg_write=1, dest=5), idex_rs=5 -> fwd_a=10; set exmem_reg_write=0 -> fwd_a=01; set dest=0 on both -> fwd_a=00.
REQ-037 Load-use, LOAD_STALL=1: idex_mem_read=1, idex_rt=8, ifid_rs=8 for one cycle -> pc_write=0, cfe_write=0, dex_flush=1 that cycle; stall_count=1; busy stays 0.
REQ-038 Load-use, LOAD_STALL=3: same stimulus -> 3 consecutive bubble cycles with busy=1 on cycles 2 and 3; stall_count=3; RUN resumes on cycle 4.
REQ-039 Branch/load coincidence: branch_taken=1 and load_use=1 in the same RUN cycle -> cfe_flush=1, dex_flush=1, pc_write=1; flush_count=1; stall_count=0.
REQ-040 Saturation and reset: CNT_W=4, 20 load-use events -> stall_count=15; rst=0 asserted mid-STALL -> pc_write=1 and counters=0 without waiting for a clock edge.
